// File: rtl/dp_execute_stage_pkg.sv
// Shared constants for the ARM data-processing execute stage.
// Opcode/condition encodings, flag bit positions, datapath widths.
package dp_execute_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 4;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Compare/test ops only touch flags, never the register file.
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/dp_execute_stage_if.sv
// Upstream operand and writeback handshake bundle of the execute stage.
// master: producer/consumer side (drives in_*, out_ready); slave: stage.
interface dp_execute_stage_if;
    import dp_execute_stage_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           opcode;
    logic [3:0]           cond;
    logic                 s_bit;
    logic [DATA_W-1:0]    rn_data;
    logic [DATA_W-1:0]    shifter_operand;
    logic                 shifter_carry;
    logic [REG_IDX_W-1:0] rd_idx;

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_result;
    logic [REG_IDX_W-1:0] out_rd_idx;
    logic                 out_wr_en;

    modport master (
        output in_valid, opcode, cond, s_bit,
        output rn_data, shifter_operand,
        output shifter_carry, rd_idx, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_rd_idx, out_wr_en
    );

    modport slave (
        input  in_valid, opcode, cond, s_bit,
        input  rn_data, shifter_operand,
        input  shifter_carry, rd_idx, out_ready,
        output in_ready, out_valid, out_result,
        output out_rd_idx, out_wr_en
    );

endinterface

// File: rtl/dp_execute_stage_cond_eval.sv
// ARM condition-field evaluator (combinational).
// Ports: cond[3:0], nzcv[3:0] in; pass out. 1111 never passes.
module cond_eval
    import dp_execute_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_execute_stage.sv
// Registered ARM data-processing execute stage; owns the NZCV flags.
// Ports: clk, rst_n, bus (slave handshake), flags_wr_en/data, flags_nzcv, c_flag.
module dp_execute_stage
    import dp_execute_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    dp_execute_stage_if.slave bus,
    input  logic            flags_wr_en,
    input  logic [3:0]      flags_wr_data,
    output logic [3:0]      flags_nzcv,
    output logic            c_flag
);

    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_result_q, out_result_d;
    logic [REG_IDX_W-1:0] out_rd_idx_q;
    logic                 out_wr_en_q, out_wr_en_d;
    logic [3:0]           nzcv_q, nzcv_d;

    logic              accept;
    logic              cond_pass;
    logic              arith;
    logic [DATA_W-1:0] a, b, logic_res, alu_res;
    logic              cin;
    logic [DATA_W:0]   sum;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    cond_eval u_cond (
        .cond (bus.cond),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    // Arithmetic ops are mapped onto one adder: a + b + cin,
    // with reverse/subtract forms swapping and inverting operands.
    always_comb begin
        arith     = 1'b0;
        a         = bus.rn_data;
        b         = bus.shifter_operand;
        cin       = 1'b0;
        logic_res = '0;
        unique case (bus.opcode)
            OP_AND, OP_TST: logic_res = bus.rn_data & bus.shifter_operand;
            OP_EOR, OP_TEQ: logic_res = bus.rn_data ^ bus.shifter_operand;
            OP_ORR: logic_res = bus.rn_data | bus.shifter_operand;
            OP_MOV: logic_res = bus.shifter_operand;
            OP_BIC: logic_res = bus.rn_data & ~bus.shifter_operand;
            OP_MVN: logic_res = ~bus.shifter_operand;
            OP_SUB, OP_CMP: begin
                arith = 1'b1;
                b     = ~bus.shifter_operand;
                cin   = 1'b1;
            end
            OP_RSB: begin
                arith = 1'b1;
                a     = bus.shifter_operand;
                b     = ~bus.rn_data;
                cin   = 1'b1;
            end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_ADC: begin
                arith = 1'b1;
                cin   = nzcv_q[C_BIT];
            end
            OP_SBC: begin
                arith = 1'b1;
                b     = ~bus.shifter_operand;
                cin   = nzcv_q[C_BIT];
            end
            OP_RSC: begin
                arith = 1'b1;
                a     = bus.shifter_operand;
                b     = ~bus.rn_data;
                cin   = nzcv_q[C_BIT];
            end
        endcase
    end

    assign sum     = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign alu_res = arith ? sum[DATA_W-1:0] : logic_res;

    always_comb begin
        nzcv_d        = nzcv_q;
        nzcv_d[N_BIT] = alu_res[DATA_W-1];
        nzcv_d[Z_BIT] = alu_res == '0;
        if (arith) begin
            nzcv_d[C_BIT] = sum[DATA_W];
            // Overflow: same-sign operands giving a different-sign sum.
            nzcv_d[V_BIT] = (a[DATA_W-1] == b[DATA_W-1])
                         && (sum[DATA_W-1] != a[DATA_W-1]);
        end else begin
            nzcv_d[C_BIT] = bus.shifter_carry;
        end
    end

    assign out_result_d = cond_pass ? alu_res : '0;
    assign out_wr_en_d  = cond_pass && !is_test_op(bus.opcode);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_idx_q <= '0;
            out_wr_en_q  <= 1'b0;
            nzcv_q       <= '0;
        end else begin
            if (accept) begin
                out_valid_q  <= 1'b1;
                out_result_q <= out_result_d;
                out_rd_idx_q <= bus.rd_idx;
                out_wr_en_q  <= out_wr_en_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // The MSR path has priority over an S-suffixed update.
            if (flags_wr_en) begin
                nzcv_q <= flags_wr_data;
            end else if (accept && cond_pass && bus.s_bit) begin
                nzcv_q <= nzcv_d;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_rd_idx = out_rd_idx_q;
    assign bus.out_wr_en  = out_wr_en_q;
    assign flags_nzcv     = nzcv_q;
    assign c_flag         = nzcv_q[C_BIT];

endmodule

// File: doc/dp_execute_stage.md
Name: dp_execute_stage

Overview:
- Downstream consumer of the barrel shifter: registered ARM data-processing execute stage.
- Takes Rn, shifter_operand and shifter carry, and evaluates the condition field against the CPSR flags it owns.
- Computes the 16 DP opcodes, updates NZCV when S=1, and presents the result to writeback over a valid/ready handshake.
- Drives c_flag back to the barrel shifter's c_flag input.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_IDX_W, 4, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  stage can accept this cycle
- opcode  in  4  DP opcode (instr[24:21])
- cond  in  4  condition field (instr[31:28])
- s_bit  in  1  set-flags request
- rn_data  in  32  first operand
- shifter_operand  in  32  second operand from barrel shifter
- shifter_carry  in  1  bit 0 of barrel shifter carry-out
- rd_idx  in  4  destination register
- flags_wr_en  in  1  direct CPSR flag write (MSR path)
- flags_wr_data  in  4  NZCV value for the direct write
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_result  out  32  ALU result
- out_rd_idx  out  4  destination register
- out_wr_en  out  1  register write required
- flags_nzcv  out  4  current {N,Z,C,V}
- c_flag  out  1  flags_nzcv[1]; feeds the barrel shifter

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_result=0, out_rd_idx=0, out_wr_en=0, flags_nzcv=0. Any in-flight result is discarded.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Accept when in_valid && in_ready.
  - Latency is 1 cycle: on the accept edge the output register loads and out_valid is set to 1.
  - No accept and out_ready=1: out_valid clears.
  - out_valid=1 and out_ready=0: all out_* hold stable.
- Condition check:
  - Evaluated combinationally against the registered flags_nzcv.
  - Encodings are EQ..AL per ARM, 0000-1110. 1111 is treated as never.
  - An instruction accepted on the cycle after an S-update sees the updated flags; there is no bypass hazard.
- Condition fail: the instruction is still accepted and still produces out_valid=1. out_wr_en=0, out_result=0, flags unchanged.
- Opcodes:
  - AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN.
  - Arithmetic uses a 33-bit sum.
  - SUB = Rn + ~op + 1; RSB = op + ~Rn + 1; ADC adds C; SBC = Rn + ~op + C; RSC = op + ~Rn + C.
- out_wr_en = cond_pass && opcode not in {TST, TEQ, CMP, CMN}.
- Flag update when cond_pass && s_bit (TST/TEQ/CMP/CMN update flags only when s_bit=1):
  - N = result[31]; Z = (result==0).
  - Logical ops: C = shifter_carry; V unchanged.
  - Arithmetic ops: C = bit 32 of the sum (1 means no borrow). V = signed overflow of the effective operands.
- Flags update on the accept edge even if the output register is stalled afterwards.
- flags_wr_en: all four flags load flags_wr_data. If an S-update occurs on the same edge, flags_wr_en wins.
- rd_idx==15 gets no special handling; PC writes belong to the branch unit.

Decomposition:
- arm_defines.vh: DP opcode constants (OP_AND..OP_MVN), condition constants (COND_EQ..COND_AL, COND_NV), flag bit positions (N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0).
- Sub-module cond_eval: combinational; inputs cond[3:0] and nzcv[3:0], output pass.
- ALU and flag register stay in dp_execute_stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, flags_nzcv=0000, in_ready=1 the cycle after release.
- ADDS with AL, Rn=0x7FFFFFFF, op=1 -> next cycle out_result=0x80000000, out_wr_en=1, NZCV=1001.
- SUBS with AL, Rn=5, op=5 -> result 0, NZCV=0110. The following MOVNE op=0x12 -> out_valid=1, out_wr_en=0, flags stay 0110.
- MOVS with AL, op=0, shifter_carry=1, flags preset to 0001 via flags_wr_en -> result 0, NZCV=0111 (V preserved).
- Back-pressure: two back-to-back accepts, out_ready=0 for 3 cycles -> first result held stable, in_ready=0; release -> second result appears exactly one cycle after the first retires; no loss or duplication.
- Simultaneous flags_wr_en=1 (data 1000) with an accepted ADDS giving NZCV=0100 -> flags_nzcv=1000 after the edge; CMP with AL, Rn=3, op=4 -> NZCV=1000, out_wr_en=0.
